// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder operand sequencer.
package adder_seq_pkg;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultSyncStages = 2;

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StIssue = 2'd2,
    StHold  = 2'd3
  } state_e;

endpackage

// File: rtl/strobe_sync.sv
// Synchronizes an asynchronous strobe and emits a single-cycle pulse on its rising edge.
module strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      edge_q <= sync_out;
    end
  end

  assign rise_o = sync_out & ~edge_q;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Loads two operands from a shared bus on strobe presses, issues them to an external
// adder for one cycle, and latches the resulting sum and carry.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_strobe,
  input  logic             clear,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic             operands_valid,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result_sum,
  output logic             result_carry,
  output logic             result_valid,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_carry_q, res_carry_d;
  logic             res_valid_q, res_valid_d;
  logic             rise;

  strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .strobe_i(load_strobe),
    .rise_o  (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoadA;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_valid_d = res_valid_q;

    // clear outranks a coincident rise; the single-cycle pulse is simply lost
    if (clear) begin
      state_d     = StLoadA;
      op_a_d      = '0;
      op_b_d      = '0;
      res_sum_d   = '0;
      res_carry_d = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoadA: begin
          if (rise) begin
            op_a_d  = data_in;
            state_d = StLoadB;
          end
        end
        StLoadB: begin
          if (rise) begin
            op_b_d  = data_in;
            state_d = StIssue;
          end
        end
        StIssue: begin
          res_sum_d   = sum_in;
          res_carry_d = carry_in;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end
        StHold: begin
          if (rise) begin
            res_valid_d = 1'b0;
            state_d     = StLoadA;
          end
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  assign operand_a      = op_a_q;
  assign operand_b      = op_b_q;
  assign operands_valid = (state_q == StIssue);
  assign result_sum     = res_sum_q;
  assign result_carry   = res_carry_q;
  assign result_valid   = res_valid_q;
  assign state          = state_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed self-checking bench for adder_operand_sequencer with a behavioural adder.
module tb_adder_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load_strobe = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] operand_a, operand_b, sum_in, result_sum;
  logic       operands_valid, carry_in, result_carry, result_valid;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  assign {carry_in, sum_in} = {1'b0, operand_a} + {1'b0, operand_b};

  adder_operand_sequencer #(
    .WIDTH(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .load_strobe   (load_strobe),
    .clear         (clear),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .operands_valid(operands_valid),
    .sum_in        (sum_in),
    .carry_in      (carry_in),
    .result_sum    (result_sum),
    .result_carry  (result_carry),
    .result_valid  (result_valid),
    .state         (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (operands_valid === 1'b1) ov_cnt++;
  endtask

  // One button press: 4 cycles high, 4 cycles low; data_in stays on the bus.
  task automatic press(input logic [7:0] d);
    data_in = d;
    load_strobe = 1'b1;
    repeat (4) tick();
    load_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    press(a);
    ov_cnt = 0;
    press(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({operand_a, operand_b, result_sum, result_carry, result_valid, operands_valid, state}
        !== 29'd0) begin
      n_err++;
      $display("FAIL reset_outputs: a=%h b=%h sum=%h c=%b v=%b ov=%b st=%0d, required all 0",
               operand_a, operand_b, result_sum, result_carry, result_valid, operands_valid,
               state);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (state !== 2'd0) begin
      n_err++;
      $display("FAIL idle_no_strobe: state=%0d required 0", state);
    end
  endtask

  task automatic test_basic();
    press(8'h01);
    n_vec++;
    if (state !== 2'd1 || operand_a !== 8'h01) begin
      n_err++;
      $display("FAIL basic_load_a: state=%0d a=%h required 1 01", state, operand_a);
    end
    ov_cnt = 0;
    press(8'h01);
    n_vec++;
    if (operand_b !== 8'h01 || ov_cnt !== 1) begin
      n_err++;
      $display("FAIL basic_load_b: b=%h ov_pulses=%0d required 01 1", operand_b, ov_cnt);
    end
    n_vec++;
    if (result_sum !== 8'h02 || result_carry !== 1'b0 || result_valid !== 1'b1 ||
        state !== 2'd3) begin
      n_err++;
      $display("FAIL basic_result: sum=%h c=%b v=%b st=%0d required 02 0 1 3",
               result_sum, result_carry, result_valid, state);
    end
  endtask

  task automatic test_hold_release();
    press(8'hEE);
    n_vec++;
    if (result_valid !== 1'b0 || state !== 2'd0 || operand_a !== 8'h01 ||
        operand_b !== 8'h01) begin
      n_err++;
      $display("FAIL hold_release: v=%b st=%0d a=%h b=%h required 0 0 01 01",
               result_valid, state, operand_a, operand_b);
    end
  endtask

  task automatic test_overflow();
    load_pair(8'hFF, 8'h01);
    n_vec++;
    if (result_sum !== 8'h00 || result_carry !== 1'b1 || state !== 2'd3) begin
      n_err++;
      $display("FAIL overflow_ff_01: sum=%h c=%b st=%0d required 00 1 3",
               result_sum, result_carry, state);
    end
    press(8'h00);
    load_pair(8'h0F, 8'h01);
    n_vec++;
    if (result_sum !== 8'h10 || result_carry !== 1'b0) begin
      n_err++;
      $display("FAIL add_0f_01: sum=%h c=%b required 10 0", result_sum, result_carry);
    end
  endtask

  task automatic test_pattern_latency();
    press(8'h00);
    load_pair(8'hAA, 8'h55);
    n_vec++;
    if (result_sum !== 8'hFF || result_carry !== 1'b0 || ov_cnt !== 1) begin
      n_err++;
      $display("FAIL pattern_aa_55: sum=%h c=%b ov=%0d required ff 0 1",
               result_sum, result_carry, ov_cnt);
    end
    press(8'h00);
    // strobe first sampled at edge k; capture expected at edge k+2
    data_in = 8'h5A;
    load_strobe = 1'b1;
    tick();
    tick();
    n_vec++;
    if (operand_a !== 8'hAA) begin
      n_err++;
      $display("FAIL latency_early: a=%h required aa at edge k+1", operand_a);
    end
    tick();
    n_vec++;
    if (operand_a !== 8'h5A) begin
      n_err++;
      $display("FAIL latency_capture: a=%h required 5a at edge k+2", operand_a);
    end
    load_strobe = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_strobe_hygiene();
    logic [1:0] max_st;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    data_in = 8'h3C;
    load_strobe = 1'b1;
    max_st = 2'd0;
    repeat (20) begin
      tick();
      if (state > max_st) max_st = state;
    end
    load_strobe = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (max_st !== 2'd1 || state !== 2'd1 || operand_a !== 8'h3C) begin
      n_err++;
      $display("FAIL held_strobe: max_state=%0d state=%0d a=%h required 1 1 3c",
               max_st, state, operand_a);
    end
    data_in = 8'hC3;
    repeat (6) tick();
    n_vec++;
    if (operand_a !== 8'h3C || state !== 2'd1) begin
      n_err++;
      $display("FAIL no_strobe_capture: a=%h st=%0d required 3c 1", operand_a, state);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    press(8'h33);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if (state !== 2'd0 || operand_a !== 8'h00) begin
      n_err++;
      $display("FAIL clear_in_load_b: st=%0d a=%h required 0 00", state, operand_a);
    end
    data_in = 8'h77;
    load_strobe = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load_strobe = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (state !== 2'd0 || operand_a !== 8'h00) begin
      n_err++;
      $display("FAIL clear_vs_rise: st=%0d a=%h required 0 00", state, operand_a);
    end
  endtask

  task automatic test_reset_mid_hold();
    load_pair(8'h03, 8'h04);
    n_vec++;
    if (result_sum !== 8'h07 || result_valid !== 1'b1 || state !== 2'd3) begin
      n_err++;
      $display("FAIL pre_reset_hold: sum=%h v=%b st=%0d required 07 1 3",
               result_sum, result_valid, state);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({operand_a, operand_b, result_sum, result_carry, result_valid, operands_valid, state}
        !== 29'd0) begin
      n_err++;
      $display("FAIL async_reset: a=%h b=%h sum=%h c=%b v=%b st=%0d required all 0",
               operand_a, operand_b, result_sum, result_carry, result_valid, state);
    end
    #10 rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_release();
    test_overflow();
    test_pattern_latency();
    test_strobe_hygiene();
    test_clear();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
